// File: rtl/sort_checker_pkg.sv
// Shared types and constants for the sort_checker stream checker.
package sort_checker_pkg;

  // Receive FSM states.
  typedef enum logic [1:0] {
    IDLE_S   = 2'd0,
    RECV_S   = 2'd1,
    REPORT_S = 2'd2
  } state_e;

  // Sink backpressure patterns selected by ready_mode_i.
  typedef enum logic [1:0] {
    RDY_ALWAYS = 2'd0,
    RDY_ALT    = 2'd1,
    RDY_LFSR   = 2'd2,
    RDY_NEVER  = 2'd3
  } ready_mode_e;

  // LFSR seed and tap mask for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3).
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Fibonacci step: shift left, feedback is XOR of tapped bits.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sort_checker_lfsr.sv
// 8-bit Fibonacci LFSR used as a pseudo-random backpressure source.
module sort_checker_lfsr
  import sort_checker_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic lfsr_bit_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next LFSR value; hold when not enabled.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // LFSR state register, seeded on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_bit_o = lfsr_q[0];

endmodule

// File: rtl/sort_checker.sv
// Stream sink that checks packets are non-decreasing, well framed and
// within length, and reports each packet with a one-cycle done pulse.
module sort_checker
  import sort_checker_pkg::*;
#(
  parameter  int DWIDTH      = 8,
  parameter  int MAX_PKT_LEN = 1024,
  localparam int LW          = $clog2(MAX_PKT_LEN) + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  input  logic [1:0]        ready_mode_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              err_order_o,
  output logic              err_frame_o,
  output logic              err_len_o,
  output logic [LW-1:0]     pkt_len_o,
  output logic [15:0]       pkt_cnt_o
);

  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_PKT_LEN);
  localparam logic [LW-1:0] LEN_SAT = LW'(MAX_PKT_LEN + 1);

  state_e            state_q,       state_d;
  logic              alt_q,         alt_d;
  logic [DWIDTH-1:0] prev_q,        prev_d;
  logic [LW-1:0]     len_q,         len_d;
  logic              ord_q,         ord_d;
  logic              lerr_q,        lerr_d;
  logic              frame_q,       frame_d;
  logic              done_q,        done_d;
  logic              pass_q,        pass_d;
  logic              err_order_q,   err_order_d;
  logic              err_frame_q,   err_frame_d;
  logic              err_len_q,     err_len_d;
  logic [LW-1:0]     pkt_len_q,     pkt_len_d;
  logic [15:0]       pkt_cnt_q,     pkt_cnt_d;

  logic              lfsr_bit;
  logic              ready;
  logic              beat;
  logic              fin;

  sort_checker_lfsr u_lfsr (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (1'b1),
    .lfsr_bit_o (lfsr_bit)
  );

  // Ready follows the selected backpressure pattern, forced low while reporting.
  always_comb begin
    ready = 1'b0;
    if (state_q != REPORT_S) begin
      case (ready_mode_e'(ready_mode_i))
        RDY_ALWAYS: ready = 1'b1;
        RDY_ALT:    ready = alt_q;
        RDY_LFSR:   ready = lfsr_bit;
        RDY_NEVER:  ready = 1'b0;
        default:    ready = 1'b0;
      endcase
    end
  end

  assign beat        = snk_valid_i && ready;
  assign snk_ready_o = ready;

  // Packet tracking, error accumulation and report capture.
  // The report fields are computed from the already-updated per-packet
  // flags so the EOP beat's own order/length check is included.
  always_comb begin
    state_d     = state_q;
    alt_d       = ~alt_q;
    prev_d      = prev_q;
    len_d       = len_q;
    ord_d       = ord_q;
    lerr_d      = lerr_q;
    frame_d     = frame_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_order_d = err_order_q;
    err_frame_d = err_frame_q;
    err_len_d   = err_len_q;
    pkt_len_d   = pkt_len_q;
    pkt_cnt_d   = pkt_cnt_q;
    fin         = 1'b0;

    case (state_q)
      IDLE_S, RECV_S: begin
        if (beat) begin
          if (snk_startofpacket_i) begin
            // SOP always starts a fresh packet; inside a packet it is a framing fault.
            if (state_q == RECV_S) begin
              frame_d = 1'b1;
            end
            prev_d = snk_data_i;
            len_d  = LW'(1);
            ord_d  = 1'b0;
            lerr_d = 1'b0;
            if (snk_endofpacket_i) begin
              fin = 1'b1;
            end else begin
              state_d = RECV_S;
            end
          end else if (state_q == IDLE_S) begin
            // Beat outside a packet: flag and drop.
            frame_d = 1'b1;
          end else begin
            prev_d = snk_data_i;
            len_d  = (len_q == LEN_SAT) ? len_q : len_q + LW'(1);
            if (snk_data_i < prev_q) begin
              ord_d = 1'b1;
            end
            if (len_q >= LEN_MAX) begin
              lerr_d = 1'b1;
            end
            if (snk_endofpacket_i) begin
              fin = 1'b1;
            end
          end
        end
      end
      REPORT_S: begin
        state_d = IDLE_S;
      end
      default: begin
        state_d = IDLE_S;
      end
    endcase

    if (fin) begin
      state_d     = REPORT_S;
      done_d      = 1'b1;
      pass_d      = ~(ord_d | frame_d | lerr_d);
      err_order_d = ord_d;
      err_frame_d = frame_d;
      err_len_d   = lerr_d;
      pkt_len_d   = len_d;
      pkt_cnt_d   = pkt_cnt_q + 16'd1;
      frame_d     = 1'b0;
    end
  end

  // State and registered report outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE_S;
      alt_q       <= 1'b1;
      prev_q      <= '0;
      len_q       <= '0;
      ord_q       <= 1'b0;
      lerr_q      <= 1'b0;
      frame_q     <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_order_q <= 1'b0;
      err_frame_q <= 1'b0;
      err_len_q   <= 1'b0;
      pkt_len_q   <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      alt_q       <= alt_d;
      prev_q      <= prev_d;
      len_q       <= len_d;
      ord_q       <= ord_d;
      lerr_q      <= lerr_d;
      frame_q     <= frame_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_order_q <= err_order_d;
      err_frame_q <= err_frame_d;
      err_len_q   <= err_len_d;
      pkt_len_q   <= pkt_len_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_order_o = err_order_q;
  assign err_frame_o = err_frame_q;
  assign err_len_o   = err_len_q;
  assign pkt_len_o   = pkt_len_q;
  assign pkt_cnt_o   = pkt_cnt_q;

endmodule

// File: tb/tb_sort_checker.sv
// Bench for sort_checker: two instances (default length limit and a limit
// of 4) share one stimulus stream; a packet-level model checks both every
// cycle, and directed literal checks pin the expected reports.
module tb_sort_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       sop, eop, valid;
  logic [1:0] mode;

  logic        rdy0, done0, pass0, ord0, frm0, lerr0;
  logic [10:0] len0;
  logic [15:0] cnt0;
  logic        rdy1, done1, pass1, ord1, frm1, lerr1;
  logic [2:0]  len1;
  logic [15:0] cnt1;

  int checks   = 0;
  int errors   = 0;
  int accepted = 0;

  always #5 clk = ~clk;

  sort_checker #(.DWIDTH(8), .MAX_PKT_LEN(1024)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .snk_data_i(data),
    .snk_startofpacket_i(sop), .snk_endofpacket_i(eop), .snk_valid_i(valid),
    .snk_ready_o(rdy0), .ready_mode_i(mode), .done_o(done0), .pass_o(pass0),
    .err_order_o(ord0), .err_frame_o(frm0), .err_len_o(lerr0),
    .pkt_len_o(len0), .pkt_cnt_o(cnt0)
  );

  sort_checker #(.DWIDTH(8), .MAX_PKT_LEN(4)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .snk_data_i(data),
    .snk_startofpacket_i(sop), .snk_endofpacket_i(eop), .snk_valid_i(valid),
    .snk_ready_o(rdy1), .ready_mode_i(mode), .done_o(done1), .pass_o(pass1),
    .err_order_o(ord1), .err_frame_o(frm1), .err_len_o(lerr1),
    .pkt_len_o(len1), .pkt_cnt_o(cnt1)
  );

  logic [31:0] a_rdy[2], a_done[2], a_pass[2], a_ord[2], a_frm[2], a_lerr[2], a_len[2], a_cnt[2];
  assign a_rdy[0]  = 32'(rdy0);  assign a_rdy[1]  = 32'(rdy1);
  assign a_done[0] = 32'(done0); assign a_done[1] = 32'(done1);
  assign a_pass[0] = 32'(pass0); assign a_pass[1] = 32'(pass1);
  assign a_ord[0]  = 32'(ord0);  assign a_ord[1]  = 32'(ord1);
  assign a_frm[0]  = 32'(frm0);  assign a_frm[1]  = 32'(frm1);
  assign a_lerr[0] = 32'(lerr0); assign a_lerr[1] = 32'(lerr1);
  assign a_len[0]  = 32'(len0);  assign a_len[1]  = 32'(len1);
  assign a_cnt[0]  = 32'(cnt0);  assign a_cnt[1]  = 32'(cnt1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  int         maxl[2] = '{1024, 4};
  bit         m_inpkt[2], m_frame[2], m_rep[2], m_r[2];
  int         m_q[2][$];
  bit [7:0]   m_lfsr;
  bit         m_alt;
  bit         e_done[2], e_pass[2], e_ord[2], e_frm[2], e_lerr[2];
  int         e_len[2], e_cnt[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_inpkt[i] = 0; m_frame[i] = 0; m_rep[i] = 0;
      m_q[i].delete();
      e_done[i] = 0; e_pass[i] = 0; e_ord[i] = 0; e_frm[i] = 0; e_lerr[i] = 0;
      e_len[i] = 0; e_cnt[i] = 0;
    end
    m_lfsr = 8'hA5;
    m_alt  = 1;
  endtask

  // A finished packet: scan the whole collected packet for descents.
  task automatic finish(input int i);
    bit o;
    int n;
    o = 0;
    n = m_q[i].size();
    for (int k = 1; k < n; k++) if (m_q[i][k] < m_q[i][k-1]) o = 1;
    e_ord[i]  = o;
    e_lerr[i] = (n > maxl[i]);
    e_frm[i]  = m_frame[i];
    e_pass[i] = !(o || (n > maxl[i]) || m_frame[i]);
    e_len[i]  = (n > maxl[i] + 1) ? maxl[i] + 1 : n;
    e_cnt[i]  = (e_cnt[i] + 1) % 65536;
    e_done[i] = 1;
    m_frame[i] = 0;
    m_inpkt[i] = 0;
    m_rep[i]   = 1;
  endtask

  task automatic step(input int i, input bit beat);
    e_done[i] = 0;
    if (m_rep[i]) begin
      m_rep[i] = 0;
    end else if (beat) begin
      if (sop) begin
        if (m_inpkt[i]) m_frame[i] = 1;
        m_q[i].delete();
        m_q[i].push_back(int'(data));
        if (eop) finish(i);
        else m_inpkt[i] = 1;
      end else if (!m_inpkt[i]) begin
        m_frame[i] = 1;
      end else begin
        m_q[i].push_back(int'(data));
        if (eop) finish(i);
      end
    end
  endtask

  // Ready is stable between edges: check it mid-cycle.
  always @(negedge clk) begin
    #2;
    if (!rst_n) model_reset();
    for (int i = 0; i < 2; i++) begin
      m_r[i] = !m_rep[i] && ((mode == 2'd0) || (mode == 2'd1 && m_alt) || (mode == 2'd2 && m_lfsr[0]));
      chk($sformatf("ready%0d", i), a_rdy[i], 32'(m_r[i]));
    end
  end

  // Advance the model on each edge, then compare all report outputs.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) step(i, valid && m_r[i]);
      m_alt  = !m_alt;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end else begin
      model_reset();
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("done%0d", i), a_done[i], 32'(e_done[i]));
      chk($sformatf("pass%0d", i), a_pass[i], 32'(e_pass[i]));
      chk($sformatf("err_order%0d", i), a_ord[i], 32'(e_ord[i]));
      chk($sformatf("err_frame%0d", i), a_frm[i], 32'(e_frm[i]));
      chk($sformatf("err_len%0d", i), a_lerr[i], 32'(e_lerr[i]));
      chk($sformatf("pkt_len%0d", i), a_len[i], 32'(e_len[i]));
      chk($sformatf("pkt_cnt%0d", i), a_cnt[i], 32'(e_cnt[i]));
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] pkt[$];

  // Offer one beat from a falling edge; return at the falling edge after acceptance.
  task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
    int  waitc;
    bit  acc;
    waitc = 0;
    acc   = 0;
    data = d; sop = s; eop = e; valid = 1'b1;
    while (!acc && waitc <= 200) begin
      #1;
      acc = rdy0;
      @(negedge clk);
      if (!acc) waitc++;
    end
    if (acc) begin
      accepted++;
    end else begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: beat %0d got no ready in 200 cycles, expected acceptance", d);
    end
  endtask

  task automatic send_pkt();
    for (int k = 0; k < pkt.size(); k++) send_beat(pkt[k], k == 0, k == pkt.size() - 1);
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; data = '0; sop = 0; eop = 0; valid = 0; mode = 2'd0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_done", 32'(done0), 0);
    chk("rst_pass", 32'(pass0), 0);
    chk("rst_len", 32'(len0), 0);
    chk("rst_cnt", 32'(cnt0), 0);
    chk("rst_ready_mode0", 32'(rdy0), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Sorted packet with a repeated value.
    pkt = '{8'd1, 8'd2, 8'd2, 8'd7, 8'd9};
    send_pkt();
    chk("p1_done_after_eop", 32'(done0), 1);
    chk("p1_pass", 32'(pass0), 1);
    chk("p1_len", 32'(len0), 5);
    chk("p1_cnt", 32'(cnt0), 1);
    chk("p1_lim4_err_len", 32'(lerr1), 1);
    chk("p1_lim4_len_sat", 32'(len1), 5);
    @(negedge clk);
    chk("p1_done_one_cycle", 32'(done0), 0);
    chk("p1_pass_held", 32'(pass0), 1);

    // Descending pair.
    pkt = '{8'd3, 8'd5, 8'd4, 8'd8};
    send_pkt();
    chk("p2_err_order", 32'(ord0), 1);
    chk("p2_pass", 32'(pass0), 0);
    chk("p2_len", 32'(len0), 4);
    @(negedge clk);

    // Alternating and LFSR backpressure, valid held high.
    for (int m = 1; m <= 2; m++) begin
      mode = 2'(m);
      pkt.delete();
      for (int v = 0; v < 16; v++) pkt.push_back(8'(v));
      accepted = 0;
      send_pkt();
      chk($sformatf("bp%0d_accepted", m), 32'(accepted), 16);
      chk($sformatf("bp%0d_pass", m), 32'(pass0), 1);
      chk($sformatf("bp%0d_len", m), 32'(len0), 16);
      chk($sformatf("bp%0d_ready_report", m), 32'(rdy0), 0);
      @(negedge clk);
    end
    mode = 2'd0;

    // Stray beat in idle, then a clean packet carries the frame error.
    send_beat(8'd9, 1'b0, 1'b0);
    pkt = '{8'd4, 8'd6};
    send_pkt();
    chk("stray_err_frame", 32'(frm0), 1);
    chk("stray_len", 32'(len0), 2);
    chk("stray_pass", 32'(pass0), 0);
    @(negedge clk);
    pkt = '{8'd1, 8'd2};
    send_pkt();
    chk("after_stray_frame_clear", 32'(frm0), 0);
    chk("after_stray_pass", 32'(pass0), 1);
    @(negedge clk);

    // Second SOP mid-packet restarts the count; 6->2 is not compared.
    send_beat(8'd5, 1'b1, 1'b0);
    send_beat(8'd6, 1'b0, 1'b0);
    send_beat(8'd2, 1'b1, 1'b0);
    send_beat(8'd3, 1'b0, 1'b0);
    send_beat(8'd4, 1'b0, 1'b1);
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    chk("restart_err_frame", 32'(frm0), 1);
    chk("restart_len", 32'(len0), 3);
    chk("restart_err_order", 32'(ord0), 0);
    chk("restart_cnt", 32'(cnt0), 7);
    @(negedge clk);

    // Valid without ready changes nothing.
    mode = 2'd3;
    data = 8'd0; sop = 1'b1; eop = 1'b1; valid = 1'b1;
    repeat (5) @(negedge clk);
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    chk("never_cnt", 32'(cnt0), 7);
    mode = 2'd0;
    @(negedge clk);

    // Over-length packet on the limit-4 instance.
    pkt = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    send_pkt();
    chk("long_lim4_err_len", 32'(lerr1), 1);
    chk("long_lim4_len", 32'(len1), 5);
    chk("long_lim4_pass", 32'(pass1), 0);
    chk("long_def_len", 32'(len0), 6);
    chk("long_def_pass", 32'(pass0), 1);
    @(negedge clk);
    send_beat(8'd7, 1'b1, 1'b1);
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    chk("single_lim4_len", 32'(len1), 1);
    chk("single_lim4_pass", 32'(pass1), 1);
    chk("single_lim4_err_len", 32'(lerr1), 0);
    chk("single_cnt", 32'(cnt1), 9);
    @(negedge clk);

    // Reset mid-packet discards it.
    send_beat(8'd1, 1'b1, 1'b0);
    send_beat(8'd2, 1'b0, 1'b0);
    send_beat(8'd3, 1'b0, 1'b0);
    valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done0), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    pkt = '{8'd1, 8'd2};
    send_pkt();
    chk("midrst_done", 32'(done0), 1);
    chk("midrst_cnt", 32'(cnt0), 1);
    chk("midrst_len", 32'(len0), 2);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_checker.md
SORT_CHECKER -- requirements
Module: sort_checker

Interface
REQ-001 Parameter DWIDTH, default 8, sink data width in bits.
REQ-002 Parameter MAX_PKT_LEN, default 1024, maximum legal packet length in beats; LW = $clog2(MAX_PKT_LEN)+1.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  sole clock, all state on rising edge.
REQ-005 rst_n_i  input  1  asynchronous active-low reset.
REQ-006 snk_data_i  input  DWIDTH  stream data, unsigned.
REQ-007 snk_startofpacket_i  input  1  first beat of packet.
REQ-008 snk_endofpacket_i  input  1  last beat of packet.
REQ-009 snk_valid_i  input  1  beat offered.
REQ-010 snk_ready_o  output  1  checker accepts beat; beat = snk_valid_i && snk_ready_o.
REQ-011 ready_mode_i  input  2  backpressure pattern: 0 always, 1 alternate, 2 LFSR, 3 never.
REQ-012 done_o  output  1  one-cycle pulse, packet report valid.
REQ-013 pass_o  output  1  last packet had no errors.
REQ-014 err_order_o  output  1  last packet had a descending pair.
REQ-015 err_frame_o  output  1  framing violation since last report.
REQ-016 err_len_o  output  1  last packet exceeded MAX_PKT_LEN.
REQ-017 pkt_len_o  output  LW  beat count of last packet, saturating at MAX_PKT_LEN+1.
REQ-018 pkt_cnt_o  output  16  packets reported since reset, wraps 16'hFFFF->0.

Function
REQ-019 FSM states IDLE_S, RECV_S, REPORT_S; IDLE_S->RECV_S on beat with SOP and not EOP; IDLE_S or RECV_S->REPORT_S on beat with EOP (SOP seen); REPORT_S->IDLE_S unconditionally after one cycle.
REQ-020 snk_ready_o SHALL be 0 in REPORT_S; otherwise per ready_mode_i: 1 / toggling each cycle starting 1 / LFSR bit 0 / 0.
REQ-021 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5, advances every cycle.
REQ-022 First beat of packet loads prev register and sets length to 1; each later beat increments length (saturating) and compares against prev.
REQ-023 Beat with snk_data_i < prev SHALL set packet order error; equal values are legal.
REQ-024 Beat with SOP and EOP together SHALL form a length-1 packet, no order check.
REQ-025 Beat in IDLE_S without SOP SHALL set frame error, be discarded, state unchanged.
REQ-026 Beat with SOP in RECV_S SHALL set frame error and restart the packet with that beat as first beat.
REQ-027 Length exceeding MAX_PKT_LEN SHALL set length error; reception continues to EOP.
REQ-028 done_o SHALL pulse in REPORT_S, exactly one cycle after the EOP beat; pass_o, err_*_o, pkt_len_o update on the same cycle and hold until next report.
REQ-029 pass_o = not (order or frame or length error); per-packet error flags clear on entering RECV_S or on a SOP+EOP beat; frame error clears after report.
REQ-030 pkt_cnt_o increments once per done_o pulse.
REQ-031 snk_valid_i high without a beat SHALL not alter any state.

Reset
REQ-032 On rst_n_i low, asynchronously: state IDLE_S, LFSR 8'hA5, alternate phase 1, done_o 0, pass_o 0, all err_*_o 0, pkt_len_o 0, pkt_cnt_o 0, prev 0.
REQ-033 Reset mid-packet SHALL discard the partial packet with no report.
REQ-034 snk_ready_o after reset follows ready_mode_i combinationally with reset state values.

Structure
REQ-035 Shared package holds state enum, ready_mode encodings, LFSR seed and tap constants.
REQ-036 One sub-module natural: sort_checker_lfsr (8-bit LFSR, enable, async reset).

Verification
REQ-037 Mode 0, packet 1,2,2,7,9 SOP/EOP correct -> done_o one cycle after EOP, pass_o 1, pkt_len_o 5, pkt_cnt_o 1.
REQ-038 Mode 0, packet 3,5,4,8 -> err_order_o 1, pass_o 0, pkt_len_o 4.
REQ-039 Mode 1 and 2, valid held high, packet 0..15 -> accepted beats equal 16, pass_o 1, snk_ready_o 0 during REPORT_S.
REQ-040 Stray beat in IDLE_S then packet 4,6 -> err_frame_o 1, pkt_len_o 2; second SOP mid-packet restarts length count.
REQ-041 MAX_PKT_LEN=4, 6-beat ascending packet -> err_len_o 1, pkt_len_o 5; single SOP+EOP beat -> pkt_len_o 1, pass_o 1.
REQ-042 rst_n_i low after 3 beats, then full packet 1,2 -> no report before reset release, one report, pkt_cnt_o 1.
